// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-memory write bundle for the boot-time loader.
// The host side (master) drives the byte stream and reload request; the
// loader side (slave) answers with ready, the write port, start and err.
`timescale 1ns/1ps
interface imem_loader_if #(
   parameter int ADDR_W = 8
);
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              reload;
   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [31:0]       wdata;
   logic              start;
   logic              err;

   modport master (
      output byte_valid, byte_data, reload,
      input  byte_ready, we, waddr, wdata, start, err
   );

   modport slave (
      input  byte_valid, byte_data, reload,
      output byte_ready, we, waddr, wdata, start, err
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader. Accepts a framed byte stream
// (LEN lo, LEN hi, 4*N little-endian word bytes, XOR checksum), issues one
// instruction-memory write per word and releases the CPU (start) only once a
// complete, checksum-clean image has been written.
`timescale 1ns/1ps
module imem_loader #(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 256
) (
   input  logic          clk,
   input  logic          rst,
   imem_loader_if.slave  bus
);

   typedef enum logic [2:0] {
      S_LEN_LO = 3'd0,
      S_LEN_HI = 3'd1,
      S_DATA   = 3'd2,
      S_CSUM   = 3'd3,
      S_RUN    = 3'd4,
      S_ERR    = 3'd5
   } state_t;

   state_t            state;
   state_t            state_nx;

   logic              rdy;
   logic              acc;
   logic              start_c;
   logic              err_c;

   logic [15:0]       len;
   logic [15:0]       len_n;
   logic [15:0]       wcnt;
   logic [15:0]       wcnt_inc;
   logic [1:0]        idx;
   logic [7:0]        csum;
   logic [7:0]        csum_n;
   logic [23:0]       asm_word;

   logic              we_r;
   logic [ADDR_W-1:0] waddr_r;
   logic [31:0]       wdata_r;

   // Frame-parsing states are the only ones that take bytes; RUN/ERR stall
   // the stream until a reload or reset.
   assign rdy      = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                     (state == S_DATA)   || (state == S_CSUM);
   assign acc      = bus.byte_valid && rdy;

   // Candidate values used by both the next-state logic and the datapath.
   assign len_n    = {bus.byte_data, len[7:0]};
   assign wcnt_inc = wcnt + 16'd1;
   assign csum_n   = csum ^ bus.byte_data;

   // State register; reset drops any frame in progress back to LEN_LO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_LEN_LO;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state decode and state-derived outputs (ready, start, err).
   always_comb begin
      state_nx = state;
      start_c  = 1'b0;
      err_c    = 1'b0;
      unique case (state)
         S_LEN_LO: begin
            if (acc) state_nx = S_LEN_HI;
         end
         S_LEN_HI: begin
            if (acc) begin
               // An empty image or one larger than memory is rejected
               // before any write is issued.
               if ((len_n == 16'd0) || (len_n > 16'(MAX_WORDS))) begin
                  state_nx = S_ERR;
               end else begin
                  state_nx = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (acc && (idx == 2'd3) && (wcnt_inc == len)) begin
               state_nx = S_CSUM;
            end
         end
         S_CSUM: begin
            if (acc) begin
               state_nx = (csum_n == 8'h00) ? S_RUN : S_ERR;
            end
         end
         S_RUN: begin
            start_c = 1'b1;
            if (bus.reload) state_nx = S_LEN_LO;
         end
         S_ERR: begin
            err_c = 1'b1;
            if (bus.reload) state_nx = S_LEN_LO;
         end
         default: begin
            state_nx = S_LEN_LO;
         end
      endcase
   end

   // Datapath: length capture, word assembly, write-port registers and the
   // running checksum. The write port holds its last address/data between
   // pulses; only we returns to 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len      <= '0;
         wcnt     <= '0;
         idx      <= '0;
         csum     <= '0;
         asm_word <= '0;
         we_r     <= 1'b0;
         waddr_r  <= '0;
         wdata_r  <= '0;
      end else begin
         we_r <= 1'b0;
         if (acc) csum <= csum_n;
         unique case (state)
            S_LEN_LO: begin
               if (acc) len[7:0] <= bus.byte_data;
            end
            S_LEN_HI: begin
               if (acc) begin
                  len[15:8] <= bus.byte_data;
                  idx       <= 2'd0;
                  wcnt      <= 16'd0;
               end
            end
            S_DATA: begin
               if (acc) begin
                  unique case (idx)
                     2'd0: asm_word[7:0]   <= bus.byte_data;
                     2'd1: asm_word[15:8]  <= bus.byte_data;
                     2'd2: asm_word[23:16] <= bus.byte_data;
                     2'd3: begin
                        we_r    <= 1'b1;
                        waddr_r <= wcnt[ADDR_W-1:0];
                        wdata_r <= {bus.byte_data, asm_word};
                        wcnt    <= wcnt_inc;
                     end
                     default: ;
                  endcase
                  idx <= idx + 2'd1;
               end
            end
            S_CSUM: ;
            S_RUN, S_ERR: begin
               // A new image starts from a clean checksum at address 0.
               if (bus.reload) begin
                  csum <= 8'h00;
                  idx  <= 2'd0;
                  wcnt <= 16'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // Drive the interface from the internal registers and decode.
   assign bus.byte_ready = rdy;
   assign bus.we         = we_r;
   assign bus.waddr      = waddr_r;
   assign bus.wdata      = wdata_r;
   assign bus.start      = start_c;
   assign bus.err        = err_c;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames from the bring-up
// list plus randomized frames, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_imem_loader;

   localparam int ADDR_W    = 8;
   localparam int MAX_WORDS = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   logic [7:0]  frame[$];
   int          exp_a[$];
   logic [31:0] exp_d[$];
   logic        exp_run;
   int          got_a[$];
   logic [31:0] got_d[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Record every cycle in which the write enable is high.
   always @(negedge clk) begin
      if (bus.we === 1'b1) begin
         got_a.push_back(int'(bus.waddr));
         got_d.push_back(bus.wdata);
      end
   end

   // Reference: interpret a complete frame by its rules.
   task automatic model();
      int n;
      logic [7:0] x;
      exp_a.delete();
      exp_d.delete();
      n = int'(frame[0]) | (int'(frame[1]) << 8);
      if (n == 0 || n > MAX_WORDS) begin
         exp_run = 1'b0;
         return;
      end
      x = 8'h00;
      foreach (frame[i]) x ^= frame[i];
      for (int w = 0; w < n; w++) begin
         exp_a.push_back(w % (1 << ADDR_W));
         exp_d.push_back({frame[2+4*w+3], frame[2+4*w+2], frame[2+4*w+1], frame[2+4*w]});
      end
      exp_run = (x == 8'h00);
   endtask

   task automatic set_frame1(input logic [7:0] c);
      frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
      frame.push_back(c);
   endtask

   // Random frame of n words; bad adds a nonzero error to the checksum.
   task automatic make_rand(input int n, input bit bad);
      logic [7:0] x;
      frame.delete();
      frame.push_back(n[7:0]);
      frame.push_back(n[15:8]);
      for (int i = 0; i < 4 * n; i++) frame.push_back(8'($urandom));
      x = 8'h00;
      foreach (frame[i]) x ^= frame[i];
      if (bad) x ^= 8'($urandom_range(1, 255));
      frame.push_back(x);
   endtask

   // Called at posedge+1; returns at posedge+1 after the last accepted byte.
   task automatic send_frame(input int nbytes, input int gap_max, input int reload_at);
      int lim;
      lim = (nbytes < 0) ? frame.size() : nbytes;
      for (int i = 0; i < lim; i++) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         bus.byte_valid = 1'b1;
         bus.byte_data  = frame[i];
         bus.reload     = (i == reload_at);
         @(posedge clk);
         #1;
         bus.byte_valid = 1'b0;
         bus.reload     = 1'b0;
      end
   endtask

   task automatic do_reload();
      bus.reload = 1'b1;
      @(posedge clk);
      #1;
      bus.reload = 1'b0;
   endtask

   task automatic cmp_writes(input string tag);
      int m;
      check({tag, "_nwr"}, 32'(got_a.size()), 32'(exp_a.size()));
      m = (got_a.size() < exp_a.size()) ? got_a.size() : exp_a.size();
      for (int i = 0; i < m; i++) begin
         check({tag, "_addr"}, 32'(got_a[i]), 32'(exp_a[i]));
         check({tag, "_data"}, got_d[i], exp_d[i]);
      end
      got_a.delete();
      got_d.delete();
   endtask

   // Outcome check right after the final byte's edge, then the write list.
   task automatic finish_check(input string tag);
      check({tag, "_start"}, 32'(bus.start), 32'(exp_run));
      check({tag, "_err"},   32'(bus.err),   32'(!exp_run));
      check({tag, "_rdy"},   32'(bus.byte_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      cmp_writes(tag);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_we"},    32'(bus.we),    32'd0);
      check({tag, "_waddr"}, 32'(bus.waddr), 32'd0);
      check({tag, "_wdata"}, bus.wdata,      32'd0);
      check({tag, "_start"}, 32'(bus.start), 32'd0);
      check({tag, "_err"},   32'(bus.err),   32'd0);
      check({tag, "_rdy"},   32'(bus.byte_ready), 32'd1);
   endtask

   task automatic pulse_async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
      got_a.delete();
      got_d.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'h00;
      bus.reload     = 1'b0;

      // Reset state while rst is held.
      #3;
      check_zero_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: clean two-word image.
      set_frame1(8'hC3);
      model();
      send_frame(-1, 0, -1);
      finish_check("clean");

      // Asynchronous reset out of RUN clears the held write port too.
      pulse_async_reset("rst_run");

      // 2: bad checksum, writes still happen, err held.
      set_frame1(8'hC2);
      model();
      send_frame(-1, 0, -1);
      finish_check("badcsum");
      for (int i = 0; i < 20; i++) begin
         check("errhold_err", 32'(bus.err), 32'd1);
         check("errhold_start", 32'(bus.start), 32'd0);
         @(posedge clk);
         #1;
      end
      check("errhold_rdy", 32'(bus.byte_ready), 32'd0);

      // 3: length errors.
      do_reload();
      frame = '{8'h00, 8'h00};
      model();
      send_frame(-1, 0, -1);
      finish_check("len0");
      do_reload();
      frame = '{8'h01, 8'h01};
      model();
      send_frame(-1, 0, -1);
      finish_check("len257");

      // 4: throttled input.
      do_reload();
      set_frame1(8'hC3);
      model();
      send_frame(-1, 5, -1);
      finish_check("throttle");

      // 5: reset after 5 bytes, then re-send.
      do_reload();
      set_frame1(8'hC3);
      send_frame(5, 0, -1);
      pulse_async_reset("rst_mid");
      model();
      send_frame(-1, 0, -1);
      finish_check("resend");

      // 6: reload from RUN, then a one-word frame with an ignored reload.
      do_reload();
      check("reload_start", 32'(bus.start), 32'd0);
      check("reload_rdy", 32'(bus.byte_ready), 32'd1);
      frame = '{8'h01, 8'h00, 8'h37, 8'h05, 8'h00, 8'h00, 8'h33};
      model();
      send_frame(-1, 0, 3);
      finish_check("oneword");

      // Randomized frames, including length errors and corrupted checksums.
      for (int k = 0; k < 12; k++) begin
         int mode;
         do_reload();
         mode = int'($urandom_range(0, 5));
         if (mode == 0) begin
            frame.delete();
            frame.push_back(8'($urandom_range(1, 255)));
            frame.push_back(8'($urandom_range(1, 255)));
         end else begin
            make_rand(int'($urandom_range(1, 6)), (mode == 1));
         end
         model();
         send_frame(-1, int'($urandom_range(0, 2)), -1);
         finish_check("rand");
      end

      // Largest accepted image fills the whole address space.
      do_reload();
      make_rand(MAX_WORDS, 1'b0);
      model();
      send_frame(-1, 0, -1);
      finish_check("maxlen");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes instructions into the instruction memory that the single-cycle CPU fetches from. It accepts a framed byte stream (length, little-endian instruction words, XOR checksum) over a valid/ready byte interface and issues one word write per instruction. It drives the CPU's `start` input high only after a complete, checksum-clean image has been written. It sits between the host/serial front end and the instruction-memory write port.

## Interface

Parameters:
- `ADDR_W`, default 8: word-address width of the instruction-memory write port.
- `MAX_WORDS`, default 256: largest accepted image length in words; must be ≤ 2^ADDR_W.

Ports:
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `byte_valid`, input, 1: `byte_data` holds a byte.
- `byte_data`, input, 8: stream byte.
- `byte_ready`, output, 1: loader can accept a byte this cycle.
- `reload`, input, 1: single-cycle request to accept a new image. Honoured only in RUN or ERR.
- `we`, output, 1: instruction-memory write enable, one-cycle pulse per word.
- `waddr`, output, ADDR_W: word address for the write.
- `wdata`, output, 32: instruction word for the write.
- `start`, output, 1: CPU run enable. High means the CPU runs; low holds the CPU in reset.
- `err`, output, 1: frame rejected.

## Operation

- **Byte acceptance.** A byte is accepted on a rising edge where `byte_valid && byte_ready`. `byte_ready` is combinational from state: it is 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 in RUN and ERR.
- **Frame format:**
  - `LEN[7:0]`, then `LEN[15:8]` (word count N).
  - 4·N data bytes, each word least-significant byte first.
  - One checksum byte C. C is chosen so that the XOR of every frame byte, including the length bytes and C, equals 0x00.
- **LEN_LO:** store the low length byte, then go to LEN_HI.
- **LEN_HI:** store the high length byte.
  - If N == 0 or N > MAX_WORDS, go to ERR.
  - Otherwise go to DATA, with byte index = 0 and word counter = 0.
- **DATA:** shift each accepted byte into `wdata` bits [8·idx+7 : 8·idx]. On the 4th byte (idx == 3):
  - register `we = 1`, `waddr = word counter`, and the assembled `wdata`;
  - increment the word counter and clear idx.
  - When the word counter reaches N, go to CSUM.
- **Running checksum.** An 8-bit register XORs every accepted byte, starting from 0x00 at LEN_LO entry.
- **CSUM:** the accepted byte is folded into the checksum.
  - If the result is 0x00, go to RUN.
  - Otherwise go to ERR.
- **RUN:** `start = 1`, `err = 0`. Stays here until `reload` or `rst`.
- **ERR:** `err = 1`, `start = 0`. Stays here until `reload` or `rst`.
- **Reload.** `reload` in RUN or ERR clears `start`, `err`, the checksum, idx and the word counter, and enters LEN_LO. `reload` in any other state is ignored.
- **Arithmetic widths:**
  - Word counter is 16 bits.
  - `waddr` is the low ADDR_W bits of the counter; no wrap is possible because N ≤ MAX_WORDS.
  - Length is compared as unsigned 16-bit.

## Timing

- **Reset values** (applied asynchronously while `rst` = 1):
  - state = LEN_LO;
  - `we` = 0, `waddr` = 0, `wdata` = 0, `start` = 0, `err` = 0;
  - checksum, idx and word counter = 0;
  - `byte_ready` = 1, since it follows from LEN_LO.
- **Reset mid-operation.** `rst` in any state aborts the frame immediately. Partially written words remain in memory, and the next frame starts at address 0.
- **Throughput.** Up to one byte per cycle. Gaps in `byte_valid` are allowed anywhere and have no effect other than delay.
- **Write pulse.** `we` is high exactly one cycle: the cycle after the edge that accepted byte 3 of a word. `waddr`/`wdata` are valid in that cycle and hold their values afterwards; `we` is 0 in every other cycle.
- **Start/err latency.** `start` or `err` rises in the cycle after the edge accepting the checksum byte, or after the LEN_HI byte for a length error.
- **Reload latency.** After `reload` in RUN, `start` falls in the cycle after the `reload` edge and `byte_ready` is 1 that same cycle.
- **Last-word and checksum back-to-back.** When the final data byte and the checksum byte arrive on consecutive edges, the last `we` pulse and the checksum acceptance overlap. Both must occur normally.

## Test plan

1. **Clean two-word image.** After reset, stream 02 00 | 93 00 50 00 | 13 01 10 00 | C3, one byte per cycle. Required:
   - `we` pulse with addr 0 / data 0x00500093;
   - `we` pulse with addr 1 / data 0x00100113;
   - `start` = 1 the cycle after C3;
   - `err` = 0 and `byte_ready` = 0 afterwards.
2. **Bad checksum.** Same frame with checksum C2. Required:
   - both `we` pulses still occur;
   - then `err` = 1, `start` = 0, `byte_ready` = 0, held for 20 cycles.
3. **Length errors.**
   - Length 00 00: `err` = 1 one cycle after the 2nd byte, no `we` ever.
   - Length 01 01 (257 > 256): same response.
4. **Throttled input.** Frame 1 with `byte_valid` toggled randomly (gaps of 0–5 cycles). Required: identical writes and `start`, with no duplicated or dropped bytes.
5. **Reset mid-frame.**
   - Assert `rst` after 5 bytes of frame 1: all outputs read 0 asynchronously.
   - Re-send frame 1: writes go to addr 0 and 1, and `start` = 1.
6. **Reload.** In RUN, pulse `reload`. Required:
   - `start` = 0 the next cycle;
   - a new one-word frame 01 00 | 37 05 00 00 | 33 writes addr 0 = 0x00000537, then `start` = 1.
   - A `reload` pulse issued during DATA is ignored.
